mc_ctrl_unit: RTL and testbench

- Moore-style multi-cycle control FSM that sequences the multi-cycle MIPS datapath.
- Decodes opcode/funct from the instruction register and drives every datapath select and write enable.
- Handshakes with the memory/IO bus through MIO_ready.
- Sits beside the datapath in the CPU top; the datapath holds no control state of its own.

---
 rtl/mc_ctrl_pkg.sv | 84 ++++++++
 rtl/mc_alu_dec.sv | 39 +++
 rtl/mc_ctrl_unit.sv | 179 +++++++++++++++++
 tb/tb_mc_ctrl_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// opcode/funct constants, ALU operation codes and the control-word struct.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_EX_R = 5'd2,
    S_WB_R = 5'd3,
    S_EX_I = 5'd4,
    S_WB_I = 5'd5,
    S_MA   = 5'd6,
    S_MR   = 5'd7,
    S_MWB  = 5'd8,
    S_MW   = 5'd9,
    S_BEQ  = 5'd10,
    S_BNE  = 5'd11,
    S_J    = 5'd12,
    S_JAL  = 5'd13,
    S_JR   = 5'd14,
    S_LUI  = 5'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic       ovf_trap;
  } ctrl_t;

  // R-type functs that have a writeback; anything else retires as a NOP.
  function automatic logic funct_known(input logic [5:0] f);
    case (f)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
      F_XOR, F_NOR, F_SLT, F_SRL: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation decode from current state and instruction fields.
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] OP,
  input  logic [5:0] Fun,
  output logic [3:0] ALU_operation
);

  always_comb begin
    ALU_operation = ALU_ADD;
    case (state)
      S_EX_R, S_WB_R: begin
        case (Fun)
          F_SUB, F_SUBU: ALU_operation = ALU_SUB;
          F_AND:         ALU_operation = ALU_AND;
          F_OR:          ALU_operation = ALU_OR;
          F_XOR:         ALU_operation = ALU_XOR;
          F_NOR:         ALU_operation = ALU_NOR;
          F_SLT:         ALU_operation = ALU_SLT;
          F_SRL:         ALU_operation = ALU_SRL;
          default:       ALU_operation = ALU_ADD;
        endcase
      end
      S_EX_I, S_WB_I: begin
        case (OP)
          OP_ANDI: ALU_operation = ALU_AND;
          OP_ORI:  ALU_operation = ALU_OR;
          OP_SLTI: ALU_operation = ALU_SLT;
          default: ALU_operation = ALU_ADD;
        endcase
      end
      S_BEQ, S_BNE: ALU_operation = ALU_SUB;
      default:      ALU_operation = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Moore multi-cycle MIPS control FSM. Optional overflow trap on add/sub/addi
// writeback is compiled in with MC_OVF_TRAP_EN.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter logic [4:0] RST_STATE = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Fun,
  input  logic       zero,
  input  logic       overflow,
  input  logic       MIO_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       CPU_MIO,
  output logic       IorD,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic [1:0] MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       Branch,
  output logic [3:0] ALU_operation,
  output logic [4:0] state,
  output logic       ovf_trap
);

  state_t cur, nxt;
  ctrl_t  ctl;

  // zero is consumed by the datapath PC-write gating, not by the FSM
  logic unused_zero;
  assign unused_zero = zero;

  mc_alu_dec u_alu_dec (
    .state         (cur),
    .OP            (OP),
    .Fun           (Fun),
    .ALU_operation (ALU_operation)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= state_t'(RST_STATE);
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF: nxt = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (OP)
          OP_R:                             nxt = (Fun == F_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:                     nxt = S_MA;
          OP_BEQ:                           nxt = S_BEQ;
          OP_BNE:                           nxt = S_BNE;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_EX_I;
          OP_LUI:                           nxt = S_LUI;
          OP_J:                             nxt = S_J;
          OP_JAL:                           nxt = S_JAL;
          default:                          nxt = S_IF;
        endcase
      end
      S_EX_R:  nxt = funct_known(Fun) ? S_WB_R : S_IF;
      S_EX_I:  nxt = S_WB_I;
      S_MA:    nxt = (OP == OP_LW) ? S_MR : S_MW;
      S_MR:    nxt = MIO_ready ? S_MWB : S_MR;
      S_MW:    nxt = MIO_ready ? S_IF : S_MW;
      default: nxt = S_IF;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (cur)
      S_IF: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.pc_write  = 1'b1;
      end
      S_ID: ctl.alu_src_b = 2'b11;
      S_EX_R: ctl.alu_src_a = 1'b1;
      S_WB_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.reg_dst   = 2'b01;
        ctl.reg_write = 1'b1;
`ifdef MC_OVF_TRAP_EN
        if (overflow && (Fun == F_ADD || Fun == F_SUB)) begin
          ctl.reg_write = 1'b0;
          ctl.ovf_trap  = 1'b1;
        end
`endif
      end
      S_EX_I, S_MA: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      S_WB_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        ctl.reg_write = 1'b1;
`ifdef MC_OVF_TRAP_EN
        if (overflow && OP == OP_ADDI) begin
          ctl.reg_write = 1'b0;
          ctl.ovf_trap  = 1'b1;
        end
`endif
      end
      S_MR: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MWB: begin
        ctl.mem_to_reg = 2'b01;
        ctl.reg_write  = 1'b1;
      end
      S_MW: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ctl.alu_src_a     = 1'b1;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.branch        = (cur == S_BEQ);
      end
      S_J: begin
        ctl.pc_source = 2'b10;
        ctl.pc_write  = 1'b1;
      end
      S_JAL: begin
        ctl.reg_dst    = 2'b10;
        ctl.mem_to_reg = 2'b11;
        ctl.reg_write  = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.pc_write   = 1'b1;
      end
      S_JR: begin
        ctl.alu_src_a = 1'b1;
        ctl.pc_write  = 1'b1;
      end
      S_LUI: begin
        ctl.mem_to_reg = 2'b10;
        ctl.reg_write  = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

`ifndef MC_OVF_TRAP_EN
  logic unused_ovf;
  assign unused_ovf = overflow;
`endif

  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign CPU_MIO     = ctl.mem_read | ctl.mem_write;
  assign IorD        = ctl.iord;
  assign IRWrite     = ctl.ir_write;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign PCSource    = ctl.pc_source;
  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign Branch      = ctl.branch;
  assign ovf_trap    = ctl.ovf_trap;
  assign state       = cur;

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Scoreboard bench for mc_ctrl_unit: stimulus pushes the expected control word
// for each cycle, a negedge monitor pops and compares.
module tb_mc_ctrl_unit;
  import mc_ctrl_pkg::*;

`ifdef MC_OVF_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] st;
    logic       mem_read, mem_write, cpu_mio, iord, ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] pc_src;
    logic       pc_write, pc_wcond, branch;
    logic [3:0] alu;
    logic       trap;
  } exp_t;

  logic clk = 1'b0, reset;
  logic [5:0] OP, Fun;
  logic zero, overflow, MIO_ready;
  logic MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch, ovf_trap;
  logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
  logic [3:0] ALU_operation;
  logic [4:0] state;

  exp_t q[$];
  int passed = 0, total = 0, cyc = 0;

  always #5 clk = ~clk;

  mc_ctrl_unit dut (
    .clk(clk), .reset(reset), .OP(OP), .Fun(Fun), .zero(zero),
    .overflow(overflow), .MIO_ready(MIO_ready), .MemRead(MemRead),
    .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation), .state(state), .ovf_trap(ovf_trap)
  );

  // Hand-written decode table: one literal row per state.
  function automatic exp_t exp_of(input state_t st, input logic [3:0] alu, input logic kill);
    exp_t e = '0;
    e.st = st; e.alu = alu;
    case (st)
      S_IF:   begin e.mem_read = 1; e.cpu_mio = 1; e.ir_write = 1; e.src_b = 2'b01; e.pc_write = 1; end
      S_ID:   e.src_b = 2'b11;
      S_EX_R: e.src_a = 1;
      S_WB_R: begin e.src_a = 1; e.reg_dst = 2'b01; e.reg_write = !kill; e.trap = kill; end
      S_EX_I, S_MA: begin e.src_a = 1; e.src_b = 2'b10; end
      S_WB_I: begin e.src_a = 1; e.src_b = 2'b10; e.reg_write = !kill; e.trap = kill; end
      S_MR:   begin e.mem_read = 1; e.cpu_mio = 1; e.iord = 1; end
      S_MWB:  begin e.mem_to_reg = 2'b01; e.reg_write = 1; end
      S_MW:   begin e.mem_write = 1; e.cpu_mio = 1; e.iord = 1; end
      S_BEQ:  begin e.src_a = 1; e.pc_wcond = 1; e.pc_src = 2'b01; e.branch = 1; end
      S_BNE:  begin e.src_a = 1; e.pc_wcond = 1; e.pc_src = 2'b01; end
      S_J:    begin e.pc_src = 2'b10; e.pc_write = 1; end
      S_JAL:  begin e.reg_dst = 2'b10; e.mem_to_reg = 2'b11; e.reg_write = 1; e.pc_src = 2'b10; e.pc_write = 1; end
      S_JR:   begin e.src_a = 1; e.pc_write = 1; end
      S_LUI:  begin e.mem_to_reg = 2'b10; e.reg_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t act, want;
    cyc++;
    if (q.size() > 0) begin
      want = q.pop_front();
      act = {state, MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegDst, RegWrite,
             MemtoReg, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, Branch,
             ALU_operation, ovf_trap};
      total++;
      if (act === want) passed++;
      else $display("FAIL ctrl cyc%0d st%0d: got %h want %h", cyc, want.st, act, want);
    end
  end

  task automatic step(input logic r, input logic rdy, input state_t st,
                      input logic [3:0] alu, input logic kill);
    reset = r; MIO_ready = rdy;
    q.push_back(exp_of(st, alu, kill));
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    OP = op; Fun = fn;
    step(0, 1, S_IF, ALU_ADD, 0);
    step(0, 1, S_ID, ALU_ADD, 0);
  endtask

  logic [5:0] rfun [8] = '{F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SRL};
  logic [3:0] ralu [8] = '{ALU_SUB, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SRL};

  initial begin
    reset = 1; OP = 0; Fun = 0; zero = 0; overflow = 0; MIO_ready = 0;
    @(posedge clk); #1;
    step(1, 0, S_IF, ALU_ADD, 0);
    step(1, 1, S_IF, ALU_ADD, 0);
    step(0, 0, S_IF, ALU_ADD, 0);          // fetch stalls without MIO_ready
    fetch(OP_R, F_ADD);
    step(0, 1, S_EX_R, ALU_ADD, 0);
    step(0, 1, S_WB_R, ALU_ADD, 0);
    for (int i = 0; i < 8; i++) begin
      fetch(OP_R, rfun[i]);
      step(0, 1, S_EX_R, ralu[i], 0);
      step(0, 1, S_WB_R, ralu[i], 0);
    end
    fetch(OP_R, 6'b111111);                // unknown funct: no writeback
    step(0, 1, S_EX_R, ALU_ADD, 0);
    fetch(OP_LW, 0);
    step(0, 1, S_MA, ALU_ADD, 0);
    for (int i = 0; i < 3; i++) step(0, 0, S_MR, ALU_ADD, 0);
    step(0, 1, S_MR, ALU_ADD, 0);
    step(0, 1, S_MWB, ALU_ADD, 0);
    fetch(OP_SW, 0);
    step(0, 1, S_MA, ALU_ADD, 0);
    step(0, 0, S_MW, ALU_ADD, 0);
    step(0, 1, S_MW, ALU_ADD, 0);
    zero = 1;
    fetch(OP_BEQ, 0); step(0, 1, S_BEQ, ALU_SUB, 0);
    fetch(OP_BNE, 0); step(0, 1, S_BNE, ALU_SUB, 0);
    zero = 0;
    fetch(OP_J, 0);   step(0, 1, S_J, ALU_ADD, 0);
    fetch(OP_JAL, 0); step(0, 1, S_JAL, ALU_ADD, 0);
    fetch(OP_R, F_JR); step(0, 1, S_JR, ALU_ADD, 0);
    fetch(OP_LUI, 0); step(0, 1, S_LUI, ALU_ADD, 0);
    fetch(OP_ORI, 0);  step(0, 1, S_EX_I, ALU_OR, 0);  step(0, 1, S_WB_I, ALU_OR, 0);
    fetch(OP_ANDI, 0); step(0, 1, S_EX_I, ALU_AND, 0); step(0, 1, S_WB_I, ALU_AND, 0);
    fetch(OP_SLTI, 0); step(0, 1, S_EX_I, ALU_SLT, 0); step(0, 1, S_WB_I, ALU_SLT, 0);
    overflow = 1;
    fetch(OP_ADDI, 0); step(0, 1, S_EX_I, ALU_ADD, 0); step(0, 1, S_WB_I, ALU_ADD, TRAP);
    fetch(OP_R, F_SUB); step(0, 1, S_EX_R, ALU_SUB, 0); step(0, 1, S_WB_R, ALU_SUB, TRAP);
    fetch(OP_R, F_ADDU); step(0, 1, S_EX_R, ALU_ADD, 0); step(0, 1, S_WB_R, ALU_ADD, 0);
    overflow = 0;
    fetch(6'b111111, 0);                   // unknown opcode retires from ID
    fetch(OP_LW, 0);
    step(0, 1, S_MA, ALU_ADD, 0);
    step(0, 0, S_MR, ALU_ADD, 0);
    step(1, 0, S_IF, ALU_ADD, 0);          // async reset seen within the MR cycle
    step(1, 1, S_IF, ALU_ADD, 0);
    fetch(OP_R, F_ADD);
    step(0, 1, S_EX_R, ALU_ADD, 0);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
